// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle pixel-fill engine for the VGA adapter plot port.
//
// On an accepted start the engine latches the fill mode, the colour seed and a
// rectangle whose far corner is clamped to the visible screen. It then scans the
// rectangle column-major and emits one pixel per clock through
// vga_x/vga_y/vga_colour/vga_plot, holding the current pixel while stall is high.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              fill request, honoured only in IDLE or DONE
//   mode               0 solid, 1 column stripes, 2 row stripes, 3 checker
//   colour             solid colour (mode 0) or XOR seed (modes 1-3)
//   x0, x1 / y0, y1    inclusive rectangle bounds
//   stall              adapter not ready: hold the current pixel
//   vga_x, vga_y       current pixel coordinate
//   vga_colour         current pixel colour
//   vga_plot           pixel valid this cycle
//   busy               high while filling
//   done               high after a fill until the next accepted start
//   pix_count          pixels plotted since the last accepted start
module vga_rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [COLOUR_W-1:0]  colour,
  input  logic [X_W-1:0]       x0,
  input  logic [X_W-1:0]       x1,
  input  logic [Y_W-1:0]       y0,
  input  logic [Y_W-1:0]       y1,
  input  logic                 stall,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [COLOUR_W-1:0]  vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done,
  output logic [X_W+Y_W-1:0]   pix_count
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic [X_W-1:0]        x1_l;
  logic [Y_W-1:0]        y0_l;
  logic [Y_W-1:0]        y1_l;
  logic [1:0]            mode_l;
  logic [COLOUR_W-1:0]   colour_l;
  logic [X_W+Y_W-1:0]    count;

  // Far corner clamped to the visible area; a start edge compares against these.
  logic [X_W-1:0] x1c;
  logic [Y_W-1:0] y1c;
  assign x1c = (x1 > X_MAX) ? X_MAX : x1;
  assign y1c = (y1 > Y_MAX) ? Y_MAX : y1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      x1_l     <= '0;
      y0_l     <= '0;
      y1_l     <= '0;
      mode_l   <= '0;
      colour_l <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_l   <= mode;
            colour_l <= colour;
            x1_l     <= x1c;
            y0_l     <= y0;
            y1_l     <= y1c;
            count    <= '0;
            // An origin beyond the clamped corner (including an origin off
            // screen) describes an empty rectangle: finish without plotting.
            if ((x0 > x1c) || (y0 > y1c)) begin
              state <= DONE;
            end else begin
              x     <= x0;
              y     <= y0;
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (!stall) begin
            count <= count + (X_W+Y_W)'(1);
            if (y == y1_l) begin
              y <= y0_l;
              if (x == x1_l) begin
                state <= DONE;
              end else begin
                x <= x + X_W'(1);
              end
            end else begin
              y <= y + Y_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pattern colour from the registered scan position and latched mode/seed.
  always_comb begin
    vga_colour = colour_l;
    case (mode_l)
      2'd0: vga_colour = colour_l;
      2'd1: vga_colour = x[COLOUR_W-1:0] ^ colour_l;
      2'd2: vga_colour = y[COLOUR_W-1:0] ^ colour_l;
      2'd3: vga_colour = {COLOUR_W{x[0] ^ y[0]}} ^ colour_l;
      default: vga_colour = colour_l;
    endcase
  end

  // The plot strobe tracks stall directly so a held pixel is never counted twice.
  assign vga_plot  = (state == FILL) && !stall;
  assign busy      = (state == FILL);
  assign done      = (state == DONE);
  assign vga_x     = x;
  assign vga_y     = y;
  assign pix_count = count;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Testbench for vga_rect_fill: directed scenarios plus randomized rectangles,
// each compared pixel by pixel against a nested-loop reference of the fill.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [2:0]  colour;
  logic [7:0]  x0, x1;
  logic [6:0]  y0, y1;
  logic        stall;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;
  logic [14:0] pix_count;

  vga_rect_fill dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .colour(colour),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .stall(stall),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference colour rule written arithmetically.
  function automatic int ref_colour(input int m, input int c, input int x, input int y);
    case (m)
      0: return c;
      1: return (x % 8) ^ c;
      2: return (y % 8) ^ c;
      default: return (((x + y) % 2) ? 7 : 0) ^ c;
    endcase
  endfunction

  // smode: 0 no stall, 1 random stall, 2 three stall cycles on the second pixel.
  // scramble: toggle start and all parameters while the fill runs.
  // abort_at: >=0 returns as soon as that many pixels have been plotted.
  task automatic run_fill(input int m, input int c, input int ax0, input int ax1,
                          input int ay0, input int ay1, input int smode,
                          input bit scramble, input int abort_at);
    int x1c, y1c, n, cycles, stalls, plotted, held, budget;
    bit seen_done, st;
    x1c = (ax1 > 159) ? 159 : ax1;
    y1c = (ay1 > 119) ? 119 : ay1;
    exp_q.delete();
    for (int xi = ax0; xi <= x1c; xi++)
      for (int yi = ay0; yi <= y1c; yi++)
        exp_q.push_back('{xi, yi, ref_colour(m, c, xi, yi)});
    n = exp_q.size();
    budget = 4 * n + 20;
    cycles = 0; stalls = 0; plotted = 0; held = 0; seen_done = 0;

    @(negedge clk);
    start = 1'b1; mode = 2'(m); colour = 3'(c);
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1); stall = 1'b0;

    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (scramble) begin
        start = 1'($urandom); mode = 2'($urandom); colour = 3'($urandom);
        x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom);
      end else begin
        start = 1'b0;
      end
      st = 0;
      if (smode == 1) st = ($urandom % 3 == 0);
      if (smode == 2 && plotted == 1 && held < 3) begin
        st = 1; held++;
      end
      stall = st;
      if (st) stalls++;
      #1;
      if (exp_q.size() == 0) begin
        chk("extra_pixel", 32'(vga_plot), 0);
      end else begin
        chk("busy_fill", 32'(busy), 1);
        chk("pix_x", 32'(vga_x), exp_q[0].x);
        chk("pix_y", 32'(vga_y), exp_q[0].y);
        chk("plot_vs_stall", 32'(vga_plot), 32'(!st));
        if (vga_plot) begin
          chk("pix_colour", 32'(vga_colour), exp_q[0].c);
          void'(exp_q.pop_front());
          plotted++;
        end
      end
      if (abort_at >= 0 && plotted == abort_at) return;
    end

    start = 1'b0; stall = 1'b0;
    chk("done_within_budget", 32'(seen_done), 1);
    chk("latency", cycles, n + 1 + stalls);
    chk("missing_pixels", exp_q.size(), 0);
    chk("pix_count", 32'(pix_count), n);
    chk("done_flag", 32'(done), 1);
    chk("busy_in_done", 32'(busy), 0);
    chk("plot_in_done", 32'(vga_plot), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = '0; colour = '0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; stall = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_colour", 32'(vga_colour), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(pix_count), 0);
    rst = 1'b0;

    // Full screen, column stripes.
    run_fill(1, 0, 0, 159, 0, 119, 0, 0, -1);
    // Clamped corner.
    run_fill(0, 5, 150, 255, 110, 127, 0, 0, -1);
    // Empty rectangle and off-screen origin.
    run_fill(2, 3, 20, 10, 5, 9, 0, 0, -1);
    run_fill(0, 1, 170, 200, 0, 3, 0, 0, -1);
    run_fill(0, 1, 0, 3, 120, 126, 0, 0, -1);
    // Single pixel.
    run_fill(3, 6, 159, 159, 119, 119, 0, 0, -1);
    // 2x2 with three stall cycles on the second pixel.
    run_fill(0, 4, 4, 5, 4, 5, 2, 0, -1);
    // 2x2 checker.
    run_fill(3, 2, 0, 1, 0, 1, 0, 0, -1);

    // Reset after 50 plots of a full-screen fill.
    run_fill(1, 0, 0, 159, 0, 119, 0, 0, 50);
    rst = 1'b1;
    #1;
    chk("midrst_plot", 32'(vga_plot), 0);
    chk("midrst_count", 32'(pix_count), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("no_resume", 32'(busy), 0);

    // Starts and parameter changes while busy are ignored; starting from DONE re-runs.
    run_fill(2, 7, 10, 17, 30, 36, 1, 1, -1);
    run_fill(2, 7, 10, 17, 30, 36, 0, 0, -1);

    // Randomized rectangles, modes, seeds and stalls.
    for (int t = 0; t < 12; t++) begin
      int rx0, ry0;
      rx0 = $urandom_range(0, 165);
      ry0 = $urandom_range(0, 123);
      run_fill($urandom_range(0, 3), $urandom_range(0, 7),
               rx0, (rx0 + $urandom_range(0, 14) > 255) ? 255 : rx0 + $urandom_range(0, 14),
               ry0, (ry0 + $urandom_range(0, 10) > 127) ? 127 : ry0 + $urandom_range(0, 10),
               $urandom_range(0, 1), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
